// File: rtl/cfu_seq_pkg.sv
// Shared types and constants for the CFU command sequencer.
package cfu_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  // funct7 value answered locally (status read and clear).
  localparam logic [6:0] STATUS_FUNCT7_DEFAULT = 7'h7F;

  // funct7 bit marking a posted (fire-and-forget) command.
  localparam int POSTED_BIT = 6;

  // Timeout counter width.
  localparam int CNT_W = 16;

  // Status word layout: {22'b0, err_sticky, 1'b0, err_count[7:0]}.
  localparam int STAT_CNT_LSB    = 0;
  localparam int STAT_CNT_W      = 8;
  localparam int STAT_STICKY_BIT = 9;

  // Builds the status response word from the sticky flag and timeout count.
  function automatic logic [31:0] status_word(input logic sticky, input logic [7:0] count);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_CNT_LSB +: STAT_CNT_W] = count;
    w[STAT_STICKY_BIT] = sticky;
    return w;
  endfunction

  // Increments an 8-bit count, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Cycle counter for the WAIT phase: cleared before each wait, advanced while
// waiting, and flags the last permitted cycle.
module seq_timeout_counter
  import cfu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST_COUNT);

endmodule

// File: rtl/cfu_cmd_sequencer.sv
// CFU command sequencer: accepts one CPU command, issues it to the conv1d
// datapath as a one-cycle start pulse, waits for completion or timeout, and
// holds the response until the CPU takes it. Status commands are answered
// locally from the sticky timeout record.
module cfu_cmd_sequencer
  import cfu_seq_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_CODE       = 32'hDEAD_BEEF,
  parameter logic [6:0]  STATUS_FUNCT7  = STATUS_FUNCT7_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        dp_start,
  output logic [6:0]  dp_cmd,
  output logic [31:0] dp_inp0,
  output logic [31:0] dp_inp1,
  input  logic        dp_done,
  input  logic [31:0] dp_result,
  output logic        busy,
  output logic        err_sticky
);

  seq_state_e  state_q,       state_d;
  logic [6:0]  dp_cmd_q,      dp_cmd_d;
  logic [31:0] dp_inp0_q,     dp_inp0_d;
  logic [31:0] dp_inp1_q,     dp_inp1_d;
  logic [31:0] rsp_payload_q, rsp_payload_d;
  logic        err_sticky_q,  err_sticky_d;
  logic [7:0]  err_count_q,   err_count_d;
  logic        dp_start_q,    dp_start_d;
  logic        rsp_valid_q,   rsp_valid_d;
  logic        cmd_ready_q,   cmd_ready_d;
  logic        busy_q,        busy_d;

  logic        tmo_clr_s;
  logic        tmo_en_s;
  logic        tmo_expire_s;
  logic [6:0]  funct7_s;
  logic        unused_fid_s;

  assign funct7_s     = cmd_payload_function_id[9:3];
  assign unused_fid_s = ^cmd_payload_function_id[2:0];

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (tmo_clr_s),
    .en     (tmo_en_s),
    .expire (tmo_expire_s)
  );

  // Next-state, latch and response logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    dp_cmd_d      = dp_cmd_q;
    dp_inp0_d     = dp_inp0_q;
    dp_inp1_d     = dp_inp1_q;
    rsp_payload_d = rsp_payload_q;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    tmo_clr_s     = 1'b0;
    tmo_en_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dp_cmd_d  = funct7_s;
          dp_inp0_d = cmd_payload_inputs_0;
          dp_inp1_d = cmd_payload_inputs_1;
          if (funct7_s == STATUS_FUNCT7) begin
            // Report the record as it stood, then clear it on the same edge.
            rsp_payload_d = status_word(err_sticky_q, err_count_q);
            err_sticky_d  = 1'b0;
            err_count_d   = 8'h00;
            state_d       = RESP;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        tmo_clr_s = 1'b1;
        if (dp_cmd_q[POSTED_BIT]) begin
          // Posted: acknowledge immediately, the datapath result is not awaited.
          rsp_payload_d = 32'h0000_0000;
          state_d       = RESP;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (dp_done) begin
          // Completion beats expiry when both land on the same cycle.
          rsp_payload_d = dp_result;
          state_d       = RESP;
        end else if (tmo_expire_s) begin
          rsp_payload_d = ERR_CODE;
          err_sticky_d  = 1'b1;
          err_count_d   = sat_inc8(err_count_q);
          state_d       = RESP;
        end else begin
          tmo_en_s = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    dp_start_d  = (state_d == ISSUE);
    rsp_valid_d = (state_d == RESP);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // Sequencer state and all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dp_cmd_q      <= 7'h00;
      dp_inp0_q     <= 32'h0000_0000;
      dp_inp1_q     <= 32'h0000_0000;
      rsp_payload_q <= 32'h0000_0000;
      err_sticky_q  <= 1'b0;
      err_count_q   <= 8'h00;
      dp_start_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dp_cmd_q      <= dp_cmd_d;
      dp_inp0_q     <= dp_inp0_d;
      dp_inp1_q     <= dp_inp1_d;
      rsp_payload_q <= rsp_payload_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      dp_start_q    <= dp_start_d;
      rsp_valid_q   <= rsp_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_payload_q;
  assign dp_start              = dp_start_q;
  assign dp_cmd                = dp_cmd_q;
  assign dp_inp0               = dp_inp0_q;
  assign dp_inp1               = dp_inp1_q;
  assign busy                  = busy_q;
  assign err_sticky            = err_sticky_q;

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Self-checking bench for cfu_cmd_sequencer: directed scenarios plus random
// transactions checked against a transaction-level model of the command rules.
module tb_cfu_cmd_sequencer;

  localparam int          T       = 8;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
  localparam logic [6:0]  STATUS  = 7'h7F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        dp_start;
  logic [6:0]  dp_cmd;
  logic [31:0] dp_inp0;
  logic [31:0] dp_inp1;
  logic        dp_done;
  logic [31:0] dp_result;
  logic        busy;
  logic        err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the sticky timeout record.
  logic       m_sticky;
  logic [7:0] m_cnt;

  cfu_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0   (cmd_payload_inputs_0),
    .cmd_payload_inputs_1   (cmd_payload_inputs_1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_payload_outputs_0),
    .dp_start               (dp_start),
    .dp_cmd                 (dp_cmd),
    .dp_inp0                (dp_inp0),
    .dp_inp1                (dp_inp1),
    .dp_done                (dp_done),
    .dp_result              (dp_result),
    .busy                   (busy),
    .err_sticky             (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_payload", rsp_payload_outputs_0, 0);
    chk("rst_dp_cmd", dp_cmd, 0);
    chk("rst_dp_inp0", dp_inp0, 0);
    chk("rst_dp_inp1", dp_inp1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask

  // One full transaction. done_at: WAIT cycle index (0-based) on which the
  // datapath finishes; values >= T mean it never does. Called #1 after an edge
  // with the sequencer idle; returns #1 after the response handshake edge.
  task automatic run_cmd(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input int done_at, input logic [31:0] res, input int hold,
                         input bit keep_valid);
    bit          is_status;
    bit          posted;
    bit          old_sticky;
    int          lat;
    logic [31:0] exp;

    is_status  = (f7 == STATUS);
    posted     = !is_status && f7[6];
    old_sticky = m_sticky;
    if (is_status) begin
      lat      = 0;
      exp      = {22'b0, m_sticky, 1'b0, m_cnt};
      m_sticky = 1'b0;
      m_cnt    = 8'h00;
    end else if (posted) begin
      lat = 1;
      exp = 32'h0;
    end else if (done_at < T) begin
      lat = 2 + done_at;
      exp = res;
    end else begin
      lat      = T + 1;
      exp      = ERR;
      m_sticky = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end

    chk("accept_ready", cmd_ready, 1);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f7, 3'($urandom)};
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    step();
    cmd_valid               = keep_valid;
    cmd_payload_function_id = 10'($urandom);
    cmd_payload_inputs_0    = $urandom;
    cmd_payload_inputs_1    = $urandom;

    for (int k = 0; k <= lat; k++) begin
      dp_done   = !is_status && !posted && (k == 1 + done_at);
      dp_result = dp_done ? res : $urandom;
      chk("dp_start", dp_start, (k == 0) && !is_status);
      chk("rsp_valid", rsp_valid, k == lat);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("busy", busy, 1);
      chk("err_sticky", err_sticky, (k == lat) ? m_sticky : old_sticky);
      if (k == 0) begin
        chk("dp_cmd", dp_cmd, f7);
        chk("dp_inp0", dp_inp0, a);
        chk("dp_inp1", dp_inp1, b);
      end
      if (k < lat) step();
    end
    chk("rsp_payload", rsp_payload_outputs_0, exp);

    // A posted command gets a stray completion while its response is pending.
    dp_done   = posted;
    dp_result = $urandom;
    for (int h = 0; h < hold; h++) begin
      step();
      dp_done = 1'b0;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_payload", rsp_payload_outputs_0, exp);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_dp_start", dp_start, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    dp_done   = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_dp_start", dp_start, 0);
  endtask

  initial begin
    logic [6:0]  f7;
    logic [31:0] res;
    int          sel;

    reset_n                 = 1'b0;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = 10'h0;
    cmd_payload_inputs_0    = 32'h0;
    cmd_payload_inputs_1    = 32'h0;
    rsp_ready               = 1'b0;
    dp_done                 = 1'b0;
    dp_result               = 32'h0;
    m_sticky                = 1'b0;
    m_cnt                   = 8'h00;
    step();
    step();
    chk_reset_values();
    reset_n = 1'b1;
    step();

    // Basic command, done on 2nd WAIT cycle, CPU stalls the response 4 cycles.
    run_cmd(7'h05, 32'h11, 32'h22, 1, 32'hCAFE_F00D, 4, 1'b0);
    // Posted command.
    run_cmd(7'h41, 32'h33, 32'h44, 0, 32'h0, 0, 1'b0);
    // Timeout, then status read and a second status read.
    run_cmd(7'h0A, 32'h55, 32'h66, 1000, 32'h0, 1, 1'b0);
    chk("sticky_after_timeout", err_sticky, 1);
    run_cmd(STATUS, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    chk("sticky_after_status", err_sticky, 0);
    run_cmd(STATUS, 32'h1, 32'h2, 0, 32'h0, 2, 1'b0);
    // Completion on exactly the expiry cycle.
    run_cmd(7'h07, 32'h77, 32'h88, T - 1, 32'h1234_5678, 0, 1'b0);
    chk("sticky_expiry_done", err_sticky, 0);

    // Reset while waiting, then a stray completion.
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'h12, 3'b101};
    cmd_payload_inputs_0    = 32'hAAAA_0001;
    cmd_payload_inputs_1    = 32'hBBBB_0002;
    step();
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    step();
    step();
    chk_reset_values();
    m_sticky  = 1'b0;
    m_cnt     = 8'h00;
    reset_n   = 1'b1;
    dp_done   = 1'b1;
    dp_result = 32'hBAD0_BAD0;
    step();
    dp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("no_rsp_after_reset", rsp_valid, 0);
      chk("idle_after_reset", busy, 0);
      step();
    end
    run_cmd(7'h13, 32'hC0, 32'hC1, 2, 32'h0BAD_CAFE, 0, 1'b0);

    // Back-to-back with cmd_valid held high.
    run_cmd(7'h21, 32'h1, 32'h2, 0, 32'hA1A1_A1A1, 0, 1'b1);
    run_cmd(7'h4F, 32'h3, 32'h4, 0, 32'h0, 1, 1'b1);
    run_cmd(7'h22, 32'h5, 32'h6, 3, 32'hB2B2_B2B2, 0, 1'b0);

    // Random mix of command kinds, completion times and response stalls.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      if (sel == 0)      f7 = STATUS;
      else if (sel == 1) f7 = 7'h40 | 7'($urandom_range(0, 62));
      else               f7 = 7'($urandom_range(0, 63));
      res = $urandom;
      run_cmd(f7, $urandom, $urandom, $urandom_range(0, T + 2), res,
              $urandom_range(0, 3), (i != 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Saturate the timeout count, then read it.
    run_cmd(STATUS, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      run_cmd(7'($urandom_range(0, 63)), $urandom, $urandom, T + 5, 32'h0, 0, 1'b0);
    end
    run_cmd(STATUS, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    chk("sticky_cleared_final", err_sticky, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cfu_cmd_sequencer.md
Name: cfu_cmd_sequencer

Overview:
- Front-end controller between the CPU's CFU command/response handshake and the conv1d datapath.
- Latches one command, issues it to the datapath as a single-cycle start pulse, then waits for datapath completion or a timeout.
- Holds the response until the CPU accepts it.
- Handles posted (no-wait) commands and one local status command, and keeps a sticky timeout error record.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without dp_done before the command is aborted (range 1..65535).
- ERR_CODE, 32'hDEAD_BEEF: response word returned on timeout.
- STATUS_FUNCT7, 7'h7F: funct7 value handled locally (status read/clear); never issued to the datapath.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_payload_function_id  in  10  [9:3]=funct7, [2:0] ignored.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts response.
- rsp_payload_outputs_0  out  32  response word.
- dp_start  out  1  one-cycle issue pulse to datapath.
- dp_cmd  out  7  latched funct7.
- dp_inp0  out  32  latched operand 0.
- dp_inp1  out  32  latched operand 1.
- dp_done  in  1  datapath result valid.
- dp_result  in  32  datapath result, sampled when dp_done=1.
- busy  out  1  1 in any state other than IDLE.
- err_sticky  out  1  set on any timeout; cleared by reset or status command.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset (reset_n=0 at a clk edge):
  - state=IDLE; rsp_valid=0, dp_start=0, err_sticky=0.
  - rsp_payload=0, dp_cmd/dp_inp0/dp_inp1=0.
  - timeout counter=0, err_count=0.
  - Reset mid-operation abandons the in-flight command; no response is produced, and a later dp_done is ignored.
- cmd_ready=1 only in IDLE. busy = (state != IDLE).
- IDLE, on cmd_valid:
  - Latch funct7 and both inputs into dp_cmd/dp_inp0/dp_inp1.
  - If funct7 == STATUS_FUNCT7: go to RESP with payload {22'b0, err_sticky, 1'b0, err_count[7:0]}; clear err_sticky and err_count in the same edge; no dp_start.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - dp_start=1, counter cleared to 0.
  - Posted command (funct7[6]=1 and not STATUS_FUNCT7): go to RESP with payload 0.
  - Otherwise go to WAIT.
- WAIT, priority in this order:
  - dp_done=1: capture dp_result into payload, go to RESP.
  - counter == TIMEOUT_CYCLES-1: payload=ERR_CODE, set err_sticky, err_count++ (saturating at 255), go to RESP.
  - Otherwise counter++.
  - A dp_done on the same cycle as expiry counts as done, not as a timeout.
- RESP:
  - rsp_valid=1, payload stable until the handshake completes.
  - rsp_ready=1: go to IDLE, rsp_valid=0 the next cycle.
  - The next command can be accepted no earlier than the cycle after the handshake.
- dp_done in IDLE, ISSUE or RESP is ignored (stray).
- dp_start must never assert outside ISSUE.
- Minimum non-posted latency, cmd accept to rsp_valid: 3 cycles (accept → ISSUE → WAIT sees dp_done → RESP).
- Counter width is 16 bits. err_count is 8 bits, saturating.

Decomposition:
- Package cfu_seq_pkg: state enum (IDLE, ISSUE, WAIT, RESP), STATUS_FUNCT7 default, posted-bit index (6), status word field offsets.
- Sub-module seq_timeout_counter: clear/enable/expire, parameterised by TIMEOUT_CYCLES. It is a natural reusable unit.
- FSM, operand latches and response register stay in the top module.

Test Plan:
- Reset, then a command with funct7=7'h05, inputs 0x11/0x22; datapath returns dp_done on the 2nd WAIT cycle with 0xCAFEF00D:
  - dp_start is high for exactly 1 cycle with dp_cmd=5.
  - Response is 0xCAFEF00D; rsp_valid holds while rsp_ready=0 for 4 cycles.
- Posted command funct7=7'h41: dp_start pulses once, response 0 two cycles after accept, and dp_done is never waited on.
- TIMEOUT_CYCLES=8, no dp_done:
  - Response is 0xDEADBEEF exactly 8 cycles after entering WAIT; err_sticky=1.
  - A following status command returns 0x0000_0201, then err_sticky=0; a second status read returns 0.
- dp_done on exactly the expiry cycle: response is dp_result, err_sticky stays 0.
- reset_n=0 during WAIT, then a stray dp_done after reset:
  - All outputs return to reset values and no rsp_valid occurs.
  - The next command completes normally.
- Back-to-back commands with cmd_valid held high: cmd_ready=0 from accept until the cycle after the rsp handshake; each command yields exactly one dp_start.
